// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access_size encodings (SIZE_WORD/HALF/BYTE/NONE)
//   - responder state enum (IDLE, BUSY, RESP)
//   - is_aligned():  alignment check for a size / low address pair
//   - byte_enable(): store byte-lane enables for a size / low address pair
package dmem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // SIZE_NONE is never a legal access, so it reports as misaligned.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_WORD: ok = (addr_lo == 2'b00);
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_WORD: be = 4'b1111;
      SIZE_HALF: be = 4'b0011 << addr_lo;
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word-organised memory with byte-enable write and
// registered read. Contents are not reset.
// Ports:
//   clk    in   clock
//   en     in   port enable; read (and optional write) happens on this edge
//   we     in   write enable, further qualified per lane by be
//   be     in   4-bit byte-lane enables
//   index  in   word index
//   wdata  in   write data, already replicated onto the lanes
//   rdata  out  registered read data (pre-write contents on a write edge)
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int INDEX_W     = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [INDEX_W-1:0] index,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Non-blocking read and write on the same edge means a store returns the
  // word as it was before the write.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (we && be[lane]) begin
          mem[index][8*lane +: 8] <= wdata[8*lane +: 8];
        end
      end
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the rv32i load/store interface.
// Accepts one access per handshake, optionally inserts wait states, performs
// byte/half/word accesses on dmem_array and returns right-justified,
// zero-extended load data with a one-cycle rvalid pulse.
//
// Build option: define DMEM_WAIT_STATE_EN to include the BUSY state and wait
// counter (WAIT_CYCLES busy cycles per access). Without it every access
// completes one cycle after acceptance and ready_n is constant 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   require_mem_access       access request
//   write_to_data_mem        1 store / 0 load
//   access_size              00 word, 01 half, 10 byte, 11 none
//   addr, wdata              byte address, right-justified store data
//   data_mem_access_ready_n  0 ready, 1 busy
//   rdata, rvalid            load data and completion pulse
//   access_err               misaligned or size 11, valid with rvalid
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        require_mem_access,
  input  logic        write_to_data_mem,
  input  logic [1:0]  access_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_mem_access_ready_n,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        access_err
);

  import dmem_pkg::*;

  localparam int INDEX_W = $clog2(DEPTH_WORDS);

`ifdef DMEM_WAIT_STATE_EN
  localparam bit         USE_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
`else
  localparam bit         USE_WAIT  = 1'b0;
`endif

  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  state_t              state;
  state_t              next_state;
  logic                accept;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [INDEX_W+1:0]  addr_q;
  logic                err_q;
  logic [31:0]         arr_rdata;

  logic                port_en;
  logic                port_write;
  logic [1:0]          port_size;
  logic [INDEX_W+1:0]  port_addr;
  logic [31:0]         port_wdata;
  logic                port_we;
  logic [3:0]          port_be;
  logic [31:0]         lane_data;
  logic [31:0]         shifted;
  logic [31:0]         load_data;

`ifdef DMEM_WAIT_STATE_EN
  logic [31:0]         wdata_q;
  logic [3:0]          cnt;
`endif

  logic unused_addr;
  assign unused_addr = ^addr[31:INDEX_W+2];

  // Requests are only sampled while ready; BUSY ignores them.
  assign accept = require_mem_access && (state != BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RESP accepts a new request just like IDLE, giving back-to-back service.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          next_state = USE_WAIT ? BUSY : RESP;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
`ifdef DMEM_WAIT_STATE_EN
        if (cnt == 4'd0) begin
          next_state = RESP;
        end
`else
        next_state = IDLE;
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are gated by state so rdata/access_err read 0 outside RESP.
  always_comb begin
`ifdef DMEM_WAIT_STATE_EN
    data_mem_access_ready_n = (state == BUSY);
`else
    data_mem_access_ready_n = 1'b0;
`endif
    rvalid     = (state == RESP);
    access_err = (state == RESP) && err_q;
    rdata      = 32'd0;
    if (state == RESP && !wr_q && !err_q) begin
      rdata = load_data;
    end
  end

  // Request latch; the error flag is decided at acceptance so it is ready
  // as a register when RESP is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      size_q <= SIZE_WORD;
      addr_q <= '0;
      err_q  <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      wdata_q <= 32'd0;
`endif
    end else if (accept) begin
      wr_q   <= write_to_data_mem;
      size_q <= access_size;
      addr_q <= addr[INDEX_W+1:0];
      err_q  <= ~is_aligned(access_size, addr[1:0]);
`ifdef DMEM_WAIT_STATE_EN
      wdata_q <= wdata;
`endif
    end
  end

`ifdef DMEM_WAIT_STATE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept && USE_WAIT) begin
      cnt <= WAIT_LOAD;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  logic unused_index_q;
  assign unused_index_q = ^addr_q[INDEX_W+1:2];
`endif

  // The array is touched only on the edge that enters RESP: directly from
  // the request inputs when there are no waits, otherwise from the latched
  // request on the last BUSY cycle. A reset in BUSY therefore drops the store.
  always_comb begin
    port_en    = accept && !USE_WAIT;
    port_write = write_to_data_mem;
    port_size  = access_size;
    port_addr  = addr[INDEX_W+1:0];
    port_wdata = wdata;
`ifdef DMEM_WAIT_STATE_EN
    if (state == BUSY && cnt == 4'd0) begin
      port_en    = 1'b1;
      port_write = wr_q;
      port_size  = size_q;
      port_addr  = addr_q;
      port_wdata = wdata_q;
    end
`endif
    case (port_size)
      SIZE_BYTE: lane_data = {4{port_wdata[7:0]}};
      SIZE_HALF: lane_data = {2{port_wdata[15:0]}};
      default:   lane_data = port_wdata;
    endcase
    port_be = byte_enable(port_size, port_addr[1:0]);
    port_we = port_en && port_write && is_aligned(port_size, port_addr[1:0]);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INDEX_W    (INDEX_W)
  ) u_array (
    .clk  (clk),
    .en   (port_en),
    .we   (port_we),
    .be   (port_be),
    .index(port_addr[INDEX_W+1:2]),
    .wdata(lane_data),
    .rdata(arr_rdata)
  );

  // Right-justify the addressed lane, then zero everything above the size.
  always_comb begin
    shifted = arr_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SIZE_BYTE: load_data = {24'd0, shifted[7:0]};
      SIZE_HALF: load_data = {16'd0, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
// Works in both builds (DMEM_WAIT_STATE_EN defined or not); expected latency
// follows the build. Uses DEPTH_WORDS = 256 so address aliasing is visible.
module tb_dmem_responder;

  import dmem_pkg::*;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;
`ifdef DMEM_WAIT_STATE_EN
  localparam int LAT = WAITS + 1;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        require_mem_access;
  logic        write_to_data_mem;
  logic [1:0]  access_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready_n;
  logic [31:0] rdata;
  logic        rvalid;
  logic        access_err;

  int vectors;
  int miscompares;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITS)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .require_mem_access     (require_mem_access),
    .write_to_data_mem      (write_to_data_mem),
    .access_size            (access_size),
    .addr                   (addr),
    .wdata                  (wdata),
    .data_mem_access_ready_n(ready_n),
    .rdata                  (rdata),
    .rvalid                 (rvalid),
    .access_err             (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for rvalid; lat = 0 means timeout.
  task automatic do_access(input bit now, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int busy);
    if (!now) @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = w;
    access_size        = sz;
    addr               = a;
    wdata              = d;
    @(posedge clk);
    #1;
    require_mem_access = 1'b0;
    lat  = 0;
    busy = 0;
    rd   = 32'hxxxx_xxxx;
    er   = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        lat = i;
        rd  = rdata;
        er  = access_err;
        break;
      end
      if (ready_n === 1'b1) busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (ready_n !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready_n: got %b expected 0", ready_n); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    vectors++; if (rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    vectors++; if (access_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", access_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat, busy;
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, rd, er, lat, busy);
    vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL word_store_lat: got %0d expected %0d", lat, LAT); end
    vectors++; if (busy !== LAT - 1) begin miscompares++; $display("[TB] FAIL word_store_busy: got %0d expected %0d", busy, LAT - 1); end
    vectors++; if (er !== 1'b0 || rd !== 32'd0) begin miscompares++; $display("[TB] FAIL word_store_resp: got err %b rdata %h expected 0/00000000", er, rd); end
    do_access(1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, rd, er, lat, busy);
    vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL word_load_lat: got %0d expected %0d", lat, LAT); end
    vectors++; if (busy !== LAT - 1) begin miscompares++; $display("[TB] FAIL word_load_busy: got %0d expected %0d", busy, LAT - 1); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL word_load_rdata: got %h expected deadbeef", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("[TB] FAIL word_load_err: got %b expected 0", er); end
  endtask

  task automatic test_lanes();
    vec_t tbl [7];
    logic [31:0] rd; logic er; int lat, busy;
    tbl = '{
      '{1'b1, SIZE_BYTE, 32'h102, 32'h0000005A, 32'h00000000, 1'b0},
      '{1'b0, SIZE_HALF, 32'h102, 32'h0,        32'h0000DE5A, 1'b0},
      '{1'b0, SIZE_WORD, 32'h100, 32'h0,        32'hDE5ABEEF, 1'b0},
      '{1'b0, SIZE_BYTE, 32'h101, 32'h0,        32'h000000BE, 1'b0},
      '{1'b0, SIZE_BYTE, 32'h103, 32'h0,        32'h000000DE, 1'b0},
      '{1'b0, SIZE_HALF, 32'h100, 32'h0,        32'h0000BEEF, 1'b0},
      '{1'b0, SIZE_WORD, 32'h500, 32'h0,        32'hDE5ABEEF, 1'b0}
    };
    foreach (tbl[i]) begin
      do_access(1'b0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd, er, lat, busy);
      vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL lanes[%0d]_lat: got %0d expected %0d", i, lat, LAT); end
      vectors++; if (rd !== tbl[i].exp_rd) begin miscompares++; $display("[TB] FAIL lanes[%0d]_rdata: got %h expected %h", i, rd, tbl[i].exp_rd); end
      vectors++; if (er !== tbl[i].exp_err) begin miscompares++; $display("[TB] FAIL lanes[%0d]_err: got %b expected %b", i, er, tbl[i].exp_err); end
    end
  endtask

  task automatic test_misalign();
    vec_t tbl [6];
    logic [31:0] rd; logic er; int lat, busy;
    tbl = '{
      '{1'b0, SIZE_WORD, 32'h101, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, SIZE_HALF, 32'h103, 32'h00001234, 32'h00000000, 1'b1},
      '{1'b0, SIZE_WORD, 32'h100, 32'h0,        32'hDE5ABEEF, 1'b0},
      '{1'b0, SIZE_HALF, 32'h101, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, SIZE_WORD, 32'h102, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{1'b0, SIZE_WORD, 32'h100, 32'h0,        32'hDE5ABEEF, 1'b0}
    };
    foreach (tbl[i]) begin
      do_access(1'b0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd, er, lat, busy);
      vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL misalign[%0d]_lat: got %0d expected %0d", i, lat, LAT); end
      vectors++; if (rd !== tbl[i].exp_rd) begin miscompares++; $display("[TB] FAIL misalign[%0d]_rdata: got %h expected %h", i, rd, tbl[i].exp_rd); end
      vectors++; if (er !== tbl[i].exp_err) begin miscompares++; $display("[TB] FAIL misalign[%0d]_err: got %b expected %b", i, er, tbl[i].exp_err); end
    end
  endtask

  task automatic test_size_none();
    vec_t tbl [3];
    logic [31:0] rd; logic er; int lat, busy;
    tbl = '{
      '{1'b1, SIZE_NONE, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{1'b0, SIZE_NONE, 32'h100, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, SIZE_WORD, 32'h100, 32'h0,        32'hDE5ABEEF, 1'b0}
    };
    foreach (tbl[i]) begin
      do_access(1'b0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, rd, er, lat, busy);
      vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL size11[%0d]_lat: got %0d expected %0d", i, lat, LAT); end
      vectors++; if (rd !== tbl[i].exp_rd) begin miscompares++; $display("[TB] FAIL size11[%0d]_rdata: got %h expected %h", i, rd, tbl[i].exp_rd); end
      vectors++; if (er !== tbl[i].exp_err) begin miscompares++; $display("[TB] FAIL size11[%0d]_err: got %b expected %b", i, er, tbl[i].exp_err); end
    end
  endtask

  task automatic test_back_to_back();
`ifndef DMEM_WAIT_STATE_EN
    vec_t tbl [4];
    tbl = '{
      '{1'b1, SIZE_WORD, 32'h300, 32'hA5A5A5A5, 32'h00000000, 1'b0},
      '{1'b1, SIZE_WORD, 32'h304, 32'h3C3C3C3C, 32'h00000000, 1'b0},
      '{1'b0, SIZE_WORD, 32'h300, 32'h0,        32'hA5A5A5A5, 1'b0},
      '{1'b0, SIZE_BYTE, 32'h305, 32'h0,        32'h0000003C, 1'b0}
    };
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = tbl[0].w;
    access_size        = tbl[0].sz;
    addr               = tbl[0].a;
    wdata              = tbl[0].d;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        write_to_data_mem = tbl[k+1].w;
        access_size       = tbl[k+1].sz;
        addr              = tbl[k+1].a;
        wdata             = tbl[k+1].d;
      end else begin
        require_mem_access = 1'b0;
      end
      @(negedge clk);
      vectors++; if (rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b[%0d]_rvalid: got %b expected 1", k, rvalid); end
      vectors++; if (ready_n !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b[%0d]_ready_n: got %b expected 0", k, ready_n); end
      vectors++; if (rdata !== tbl[k].exp_rd) begin miscompares++; $display("[TB] FAIL b2b[%0d]_rdata: got %h expected %h", k, rdata, tbl[k].exp_rd); end
    end
    @(negedge clk);
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_rvalid: got %b expected 0", rvalid); end
`else
    logic [31:0] rd; logic er; int lat, busy;
    // A request held during BUSY must not be taken as a second access.
    @(negedge clk);
    require_mem_access = 1'b1;
    write_to_data_mem  = 1'b0;
    access_size        = SIZE_WORD;
    addr               = 32'h100;
    @(posedge clk);
    #1;
    addr = 32'h101;
    lat  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rvalid === 1'b1) begin lat = i; break; end
    end
    require_mem_access = 1'b0;
    vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL busy_ignore_lat: got %0d expected %0d", lat, LAT); end
    vectors++; if (rdata !== 32'hDE5ABEEF || access_err !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_ignore_resp: got %h/%b expected de5abeef/0", rdata, access_err); end
    @(negedge clk);
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_ignore_idle: got rvalid %b expected 0", rvalid); end
    // A request presented during RESP is accepted immediately.
    do_access(1'b0, 1'b0, SIZE_WORD, 32'h100, 32'h0, rd, er, lat, busy);
    do_access(1'b1, 1'b0, SIZE_HALF, 32'h102, 32'h0, rd, er, lat, busy);
    vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL resp_accept_lat: got %0d expected %0d", lat, LAT); end
    vectors++; if (rd !== 32'h0000DE5A) begin miscompares++; $display("[TB] FAIL resp_accept_rdata: got %h expected 0000de5a", rd); end
`endif
  endtask

  task automatic test_reset_busy();
    logic [31:0] rd; logic er; int lat, busy;
    do_access(1'b0, 1'b1, SIZE_WORD, 32'h200, 32'hCAFEF00D, rd, er, lat, busy);
    @(negedge clk);
    require_mem_access = 1'b1;
`ifdef DMEM_WAIT_STATE_EN
    write_to_data_mem  = 1'b1;
    access_size        = SIZE_WORD;
    addr               = 32'h200;
    wdata              = 32'h11111111;
    @(posedge clk);
    #1;
    require_mem_access = 1'b0;
    @(negedge clk);
    vectors++; if (ready_n !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_busy_pre: got ready_n %b expected 1", ready_n); end
`else
    write_to_data_mem  = 1'b0;
    access_size        = SIZE_WORD;
    addr               = 32'h200;
    @(posedge clk);
    #1;
    require_mem_access = 1'b0;
    vectors++; if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL rst_resp_pre: got %b/%h expected 1/cafef00d", rvalid, rdata); end
`endif
    rst = 1'b1;
    #1;
    vectors++; if (ready_n !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_ready_n: got %b expected 0", ready_n); end
    vectors++; if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_rvalid: got %b expected 0", rvalid); end
    vectors++; if (rdata !== 32'd0 || access_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_data: got %h/%b expected 0/0", rdata, access_err); end
    @(negedge clk);
    rst = 1'b0;
    do_access(1'b0, 1'b0, SIZE_WORD, 32'h200, 32'h0, rd, er, lat, busy);
    vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("[TB] FAIL rst_store_dropped: got %h expected cafef00d", rd); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("[TB] FAIL rst_after_lat: got %0d expected %0d", lat, LAT); end
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b0;
    require_mem_access = 1'b0;
    write_to_data_mem  = 1'b0;
    access_size        = SIZE_WORD;
    addr               = 32'd0;
    wdata              = 32'd0;
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_size_none();
    test_back_to_back();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32i core: the memory-side end of the load/store request interface that the core's memory-stage control drives. It accepts one access per handshake, optionally inserts wait states, performs byte/half/word reads and writes on an internal word-organised array, and returns right-justified, zero-extended read data. Sign extension for LB/LH stays in the core's load path.

## Interface
- DEPTH_WORDS, default 1024: array depth in 32-bit words; power of two.
- WAIT_CYCLES, default 2: busy cycles inserted per access when the wait-state feature is compiled in; 0 to 15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- require_mem_access  in  1  access request; sampled only while data_mem_access_ready_n = 0.
- write_to_data_mem  in  1  1: store, 0: load; qualified by require_mem_access.
- access_size  in  2  00 word, 01 half, 10 byte, 11 none (always an error).
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- data_mem_access_ready_n  out  1  0: ready to accept, 1: busy.
- rdata  out  32  load data, valid when rvalid = 1.
- rvalid  out  1  one-cycle completion pulse, for loads and for stores.
- access_err  out  1  valid with rvalid: misaligned access or size 11.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: ready_n = 0.
  - On require_mem_access = 1, latch write, size, addr and wdata.
  - Go to BUSY if waits are enabled and WAIT_CYCLES > 0, else go to RESP.
- BUSY: ready_n = 1. The counter loads WAIT_CYCLES-1 on entry and decrements each cycle. When the counter is 0, go to RESP. Request inputs are ignored.
- RESP: rvalid = 1 and ready_n = 0 for exactly one cycle.
  - A new request in RESP is accepted exactly as in IDLE (back-to-back).
  - With no new request, return to IDLE.
- Alignment:
  - Word requires addr[1:0] = 00.
  - Half requires addr[0] = 0.
  - Byte is always aligned.
  - Misaligned or size 11: no array write, rdata = 0, access_err = 1 in RESP.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias.
- Store byte enables:
  - Byte: 0001 shifted left by addr[1:0].
  - Half: 0011 shifted left by addr[1:0].
  - Word: 1111.
  - Lane data is wdata replicated, so wdata[7:0] or wdata[15:0] lands on the enabled lanes.
- Store commit: on the clock edge that enters RESP. The read path returns the pre-write word; rdata for a store is don't-care and driven 0.
- Load data: array word shifted right by 8·addr[1:0], then masked to 8, 16 or 32 bits; upper bits are zero.

## Timing
- Reset values: ready_n = 0, rvalid = 0, rdata = 0, access_err = 0, state IDLE, counter 0.
- Array contents are not reset.
- Latency, request-accept edge to rvalid high:
  - 1 cycle with waits disabled or WAIT_CYCLES = 0.
  - WAIT_CYCLES + 1 cycles with waits enabled.
- Throughput: one access per cycle without waits; one per WAIT_CYCLES + 1 cycles with waits.
- rdata and access_err are registered. They hold their values only during RESP and are 0 in all other states.
- Reset asserted in BUSY: the pending store is discarded (never committed) and the state returns to IDLE immediately.
- A request while ready_n = 1 is a protocol violation and is ignored.

## Configuration
- DMEM_WAIT_STATE_EN defined: BUSY state and wait counter are present, and WAIT_CYCLES applies.
- DMEM_WAIT_STATE_EN undefined: no BUSY state or counter, WAIT_CYCLES is unused, ready_n is constant 0, and every access completes in 1 cycle.

## Structure
- Shared package dmem_pkg:
  - access_size encodings: SIZE_WORD = 00, SIZE_HALF = 01, SIZE_BYTE = 10, SIZE_NONE = 11.
  - State enum: IDLE, BUSY, RESP.
  - Alignment-check function and byte-enable function.
- Sub-module dmem_array: synchronous single-port word array with a 4-bit byte-enable write and a registered read.
- dmem_responder contains the FSM, counter, latches, alignment check and lane extraction.

## Test plan
- Word store then load, waits enabled, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to 0x100, then load word from 0x100.
  - rvalid on cycle 3 after each accept; ready_n = 1 for 2 cycles per access; rdata = 0xDEADBEEF, access_err = 0.
- Byte and half lane handling:
  - After the word above, store byte 0x5A to 0x102, then load half from 0x102.
  - rdata = 0x0000DE5A; the word at 0x100 reads 0xDE5ABEEF.
- Misalignment:
  - Load word at 0x101: access_err = 1, rdata = 0.
  - Store half 0x1234 at 0x103: access_err = 1 and the word is unchanged.
- Size 11: request with access_size 11 gives access_err = 1 and no write.
- Back-to-back without waits (macro undefined):
  - Requests on consecutive cycles complete with rvalid on consecutive cycles.
  - ready_n stays 0 throughout.
- Reset mid-BUSY: assert rst one cycle into a store of 0x11111111 to 0x200.
  - Outputs go to reset values immediately.
  - A later load from 0x200 returns the prior contents.
